// File: rtl/ps2_kb_event_rx.sv
// PS/2 keyboard receiver: input synchronisation and glitch filtering, frame
// checking, scan-code set 2 prefix decoding, a first-word-fall-through event
// FIFO and a table of currently held keys.
module ps2_kb_event_rx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned MAX_HELD    = 4,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    input  logic                          ev_ready,
    input  logic                          clear_err,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [MAX_HELD-1:0]           held_valid,
    output logic [9*MAX_HELD-1:0]         held_codes,
    output logic                          any_held,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          fifo_ovf
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // input path
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;

    // frame FSM
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          perr_set, ferr_set;

    // decoder
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [2:0]    skip_q, skip_d;
    logic          push;
    logic [9:0]    push_data;

    // FIFO
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop, full, wr_en, ovf_set;
    logic [9:0]    head;

    // held-key table
    logic [MAX_HELD-1:0] held_valid_q, held_valid_d;
    logic [8:0]          held_code_q [MAX_HELD];
    logic [8:0]          held_code_d [MAX_HELD];
    logic                found, placed;

    // sticky flags
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          fifo_ovf_q, fifo_ovf_d;

    // Synchronise both lines and accept a clock level only once it has held steady
    always_comb begin
        clk_s1_d   = PS2_CLK;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = PS2_DAT;
        dat_s2_d   = dat_s1_q;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d     = clk_s2_q;
                filt_cnt_d = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fall = filt_q & ~filt_d;
    end

    // Frame FSM: one bit per filtered falling edge, with a mid-frame timeout
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        perr_set     = 1'b0;
        ferr_set     = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!dat_s2_q) ferr_set = 1'b1;
                    if (!(^{shift_q, par_q})) perr_set = 1'b1;
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d  = S_IDLE;
                ferr_set = 1'b1;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Prefix decoder: E0/F0 set flags, E1 swallows the rest of the pause sequence
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        skip_d    = skip_q;
        push      = 1'b0;
        push_data = {ext_q, brk_q, byte_q};
        if (byte_valid_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (byte_q)
                    8'hE0: ext_d  = 1'b1;
                    8'hF0: brk_d  = 1'b1;
                    8'hE1: skip_d = 3'd7;
                    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                    default: begin
                        push  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Event FIFO: a push into a full FIFO is still taken when a pop frees the head
    always_comb begin
        pop      = (cnt_q != '0) & ev_ready;
        full     = (cnt_q == CW'(FIFO_DEPTH));
        wr_en    = push & (~full | pop);
        ovf_set  = push & full & ~pop;
        mem_d    = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Held-key table, driven by every decoded event whether or not the FIFO took it
    always_comb begin
        held_valid_d = held_valid_q;
        held_code_d  = held_code_q;
        found        = 1'b0;
        placed       = 1'b0;
        if (push) begin
            for (int unsigned i = 0; i < MAX_HELD; i++) begin
                if (held_valid_q[i] && held_code_q[i] == {push_data[9], push_data[7:0]})
                    found = 1'b1;
            end
            if (push_data[8]) begin
                for (int unsigned i = 0; i < MAX_HELD; i++) begin
                    if (held_valid_q[i] && held_code_q[i] == {push_data[9], push_data[7:0]}) begin
                        held_valid_d[i] = 1'b0;
                        held_code_d[i]  = '0;
                    end
                end
            end else if (!found) begin
                for (int unsigned i = 0; i < MAX_HELD; i++) begin
                    if (!placed && !held_valid_q[i]) begin
                        held_valid_d[i] = 1'b1;
                        held_code_d[i]  = {push_data[9], push_data[7:0]};
                        placed          = 1'b1;
                    end
                end
            end
        end
    end

    // Sticky error flags: a new error in the clearing cycle keeps the flag set
    always_comb begin
        parity_err_d = (parity_err_q & ~clear_err) | perr_set;
        frame_err_d  = (frame_err_q  & ~clear_err) | ferr_set;
        fifo_ovf_d   = (fifo_ovf_q   & ~clear_err) | ovf_set;
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            skip_q       <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            held_valid_q <= '0;
            held_code_q  <= '{default: '0};
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            fifo_ovf_q   <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            dat_s1_q     <= dat_s1_d;
            dat_s2_q     <= dat_s2_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            skip_q       <= skip_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            fifo_ovf_q   <= fifo_ovf_d;
        end
    end

    // Output mapping
    always_comb begin
        head       = mem_q[rd_ptr_q];
        ev_valid   = (cnt_q != '0);
        ev_code    = ev_valid ? head[7:0] : 8'h00;
        ev_ext     = ev_valid & head[9];
        ev_brk     = ev_valid & head[8];
        fifo_count = cnt_q;
        held_valid = held_valid_q;
        held_codes = '0;
        for (int unsigned i = 0; i < MAX_HELD; i++) begin
            held_codes[9*i +: 9] = held_code_q[i];
        end
        any_held   = |held_valid_q;
        parity_err = parity_err_q;
        frame_err  = frame_err_q;
        fifo_ovf   = fifo_ovf_q;
    end

endmodule

// File: tb/tb_ps2_kb_event_rx.sv
// Directed bench for ps2_kb_event_rx: PS/2 frames are bit-banged on the
// raw lines, expected events go into a queue and are compared as popped.
module tb_ps2_kb_event_rx;

    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned MAX_HELD    = 4;
    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 2000;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         ps2_clk, ps2_dat;
    logic                         ev_ready, clear_err;
    logic                         ev_valid, ev_ext, ev_brk;
    logic [7:0]                   ev_code;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic [MAX_HELD-1:0]          held_valid;
    logic [9*MAX_HELD-1:0]        held_codes;
    logic                         any_held, parity_err, frame_err, fifo_ovf;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [9:0]  exp_q[$];

    always #5 clk = ~clk;

    ps2_kb_event_rx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_HELD   (MAX_HELD),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .ev_ready  (ev_ready),
        .clear_err (clear_err),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_brk    (ev_brk),
        .fifo_count(fifo_count),
        .held_valid(held_valid),
        .held_codes(held_codes),
        .any_held  (any_held),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .fifo_ovf  (fifo_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(20);
        ps2_clk = 1'b1;
        cyc(10);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_dat = 1'b1;
        cyc(20);
    endtask

    task automatic send_ev(input logic ext, input logic brk, input logic [7:0] code);
        if (ext) send_byte(8'hE0, 1'b0, 1'b0);
        if (brk) send_byte(8'hF0, 1'b0, 1'b0);
        exp_q.push_back({ext, brk, code});
        send_byte(code, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && ev_valid === 1'b0) break;
            cyc(1);
        end
        chk(tag, (exp_q.size() == 0 && ev_valid === 1'b0), 1'b1);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
        cyc(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ev_valid"},   ev_valid,   0);
        chk({tag, "_ev_head"},    {ev_ext, ev_brk, ev_code}, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_held_valid"}, held_valid, 0);
        chk({tag, "_held_codes"}, held_codes, 0);
        chk({tag, "_any_held"},   any_held,   0);
        chk({tag, "_errs"},       {parity_err, frame_err, fifo_ovf}, 0);
    endtask

    // Scoreboard: every popped head must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            chk("ev_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("ev_head", {ev_ext, ev_brk, ev_code}, exp_q.pop_front());
        end
    end

    // Hard stop in case something hangs
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] codes [9];
        logic       hit;
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        ev_ready  = 1'b1;
        clear_err = 1'b0;
        rst_n     = 1'b0;
        cyc(5);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        cyc(30);

        // A make
        send_ev(1'b0, 1'b0, 8'h1C);
        wait_drain("drain_1c");
        chk("held_1c_valid", held_valid, 4'b0001);
        chk("held_1c_codes", held_codes, {27'd0, 9'h01C});
        chk("held_1c_any", any_held, 1'b1);

        // A break, then extended make / break
        send_ev(1'b0, 1'b1, 8'h1C);
        wait_drain("drain_1c_brk");
        chk("held_after_1c_brk", any_held, 1'b0);
        send_ev(1'b1, 1'b0, 8'h75);
        wait_drain("drain_e075");
        chk("held_e075_codes", held_codes, {27'd0, 9'h175});
        chk("held_e075_valid", held_valid, 4'b0001);
        send_ev(1'b1, 1'b1, 8'h75);
        wait_drain("drain_e0f075");
        chk("held_e0f075_any", any_held, 1'b0);
        chk("held_e0f075_valid", held_valid, 4'b0000);

        // Parity error
        send_byte(8'h1C, 1'b1, 1'b0);
        cyc(20);
        chk("par_err_set", {parity_err, frame_err, ev_valid}, 3'b100);
        pulse_clear();
        chk("par_err_clr", parity_err, 1'b0);

        // Stop bit error
        send_byte(8'h1C, 1'b0, 1'b1);
        cyc(20);
        chk("stop_err_set", {parity_err, frame_err, ev_valid}, 3'b010);
        pulse_clear();
        chk("stop_err_clr", frame_err, 1'b0);

        // Timeout after 6 bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        cyc(TIMEOUT_CYC - 200);
        chk("timeout_not_yet", frame_err, 1'b0);
        cyc(210);
        chk("timeout_frame_err", frame_err, 1'b1);
        pulse_clear();
        send_ev(1'b0, 1'b0, 8'h23);
        wait_drain("drain_23");
        chk("after_timeout_errs", {parity_err, frame_err}, 2'b00);
        send_ev(1'b0, 1'b1, 8'h23);
        wait_drain("drain_23_brk");

        // Fill the FIFO past capacity
        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < int'(FIFO_DEPTH)) exp_q.push_back({2'b00, codes[i]});
            send_byte(codes[i], 1'b0, 1'b0);
        end
        cyc(10);
        chk("full_count", fifo_count, FIFO_DEPTH);
        chk("full_ovf", fifo_ovf, 1'b1);
        chk("full_head", {ev_valid, ev_ext, ev_brk, ev_code}, {3'b100, 8'h15});
        chk("full_held_valid", held_valid, 4'hF);
        chk("full_held_codes", held_codes, {9'h02D, 9'h024, 9'h01D, 9'h015});
        pulse_clear();
        chk("ovf_clr", fifo_ovf, 1'b0);

        // Push while full with a pop in the same cycle
        exp_q.push_back({2'b00, 8'h4B});
        hit = 1'b0;
        fork
            send_byte(8'h4B, 1'b0, 1'b0);
            begin
                for (int i = 0; i < 1000; i++) begin
                    if (dut.byte_valid_q === 1'b1) begin
                        hit = 1'b1;
                        break;
                    end
                    cyc(1);
                end
                chk("sync_push_seen", hit, 1'b1);
                ev_ready = 1'b1;
                cyc(1);
                ev_ready = 1'b0;
                chk("pushpop_count", fifo_count, FIFO_DEPTH);
                chk("pushpop_ovf", fifo_ovf, 1'b0);
                chk("pushpop_head", ev_code, 8'h1D);
            end
        join
        ev_ready = 1'b1;
        wait_drain("drain_full");
        chk("held_unchanged", held_codes, {9'h02D, 9'h024, 9'h01D, 9'h015});

        // Pause sequence produces nothing
        send_byte(8'hE1, 1'b0, 1'b0);
        send_byte(8'h14, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'hE1, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h14, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        cyc(20);
        chk("pause_no_event", {ev_valid, fifo_count}, 0);
        send_ev(1'b0, 1'b0, 8'h1C);
        wait_drain("drain_after_pause");

        // Reset in the middle of a frame
        ev_ready = 1'b0;
        send_ev(1'b0, 1'b0, 8'h2B);
        cyc(10);
        chk("pre_reset_count", fifo_count, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        cyc(2);
        chk_reset_outputs("midreset");
        rst_n    = 1'b1;
        ev_ready = 1'b1;
        cyc(20);
        send_ev(1'b0, 1'b0, 8'h4B);
        wait_drain("drain_after_reset");
        chk("held_after_reset", held_codes, {27'd0, 9'h04B});

        chk("queue_empty_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_kb_event_rx.md
Name: ps2_kb_event_rx

Overview:
Parametrised PS/2 keyboard receiver that replaces the single-keycode/press-flag keyboard front end. It synchronises and filters PS2_CLK/PS2_DAT, checks each frame, and decodes scan-code set 2 prefixes (E0 extended, F0 break, E1 pause). It pushes make/break events into a FIFO and tracks up to MAX_HELD simultaneously held keys for game logic and the hex/LED display path.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, ≥2.
MAX_HELD, 4, held-key table slots, 1..8.
FILTER_LEN, 8, Clk cycles the synchronised PS2_CLK must be stable before a level change is accepted.
TIMEOUT_CYC, 100000, Clk cycles without a falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
PS2_CLK  in  1  raw PS/2 clock, asynchronous
PS2_DAT  in  1  raw PS/2 data, asynchronous
ev_ready  in  1  consumer pops the head event when ev_valid is also high
clear_err  in  1  clears the sticky error flags
ev_valid  out  1  FIFO not empty
ev_code  out  8  head event scan code
ev_ext  out  1  head event had the E0 prefix
ev_brk  out  1  head event is a break (release)
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
held_valid  out  MAX_HELD  slot occupied
held_codes  out  9*MAX_HELD  per slot {ext,code}; slot i is at bits [9i+8:9i]
any_held  out  1  OR of held_valid
parity_err  out  1  sticky parity error
frame_err  out  1  sticky start/stop/timeout error
fifo_ovf  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset=0 at a Clk edge: all outputs 0, FIFO empty, held table cleared, frame FSM in IDLE, prefix flags cleared, synchronisers and filter set to 1. Reset takes effect mid-frame and aborts the frame.
- Input path: 2-flop synchroniser on each line. Filtered clock changes level only after FILTER_LEN consecutive equal samples. A falling edge of the filtered clock samples the synchronised data.
- Frame FSM, one bit per falling edge:
  - IDLE: bit=0 goes to DATA; bit=1 stays in IDLE with no error.
  - DATA: shift 8 bits in, LSB first, then go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: stop=1 with odd parity over data+parity hands the byte to the decoder. Parity wrong sets parity_err. Stop=0 sets frame_err. Byte is discarded on any error. Always returns to IDLE.
  - Timeout: outside IDLE, TIMEOUT_CYC cycles with no falling edge returns to IDLE and sets frame_err.
- Decoder (byte valid for 1 cycle):
  - E0 sets ext. F0 sets brk. E1 sets skip=7; the next 7 bytes are discarded, with no event.
  - 00, AA, EE, FA, FE, FF are discarded and do not clear the flags.
  - Any other byte emits event {ext,brk,code}, then clears ext and brk.
- Latency: event is pushed on the Clk edge after the byte-valid cycle. ev_valid rises the following cycle.
- FIFO is first-word-fall-through; ev_* show the head entry.
  - Pop happens on ev_valid & ev_ready.
  - Push is accepted if not full, or if a pop occurs in the same cycle; fifo_count is then unchanged.
  - Push when full with no pop: event is dropped and fifo_ovf is set.
  - ev_ready with an empty FIFO has no effect.
- Held table, updated on every emitted event, including events dropped by the FIFO:
  - Make with {ext,code} already present: no change (typematic repeat).
  - Make not present: insert into the lowest-index free slot. If no slot is free, ignore.
  - Break: clear the matching slot. If there is no match, no change.
- Sticky flags: clear_err clears them. An error event in the same cycle as clear_err wins, and the flag is set.

Test Plan:
- Frame 1C (A make) with correct parity and stop → one event {ext=0,brk=0,code=1C}; held slot0=0_1C; any_held=1.
- Sequence E0 F0 75 after E0 75 → two events, {1,0,75} then {1,1,75}; held slot cleared; any_held=0.
- Frame 1C with parity bit inverted → no event; parity_err=1; clear_err pulse → parity_err=0.
- 6 bits sent, then line idle for TIMEOUT_CYC+10 → frame_err=1, FSM in IDLE; next valid frame 23 → event code 23.
- ev_ready=0 with FIFO_DEPTH+1 distinct makes → fifo_count=FIFO_DEPTH, fifo_ovf=1, head=first code; held table keeps first MAX_HELD codes; push with simultaneous pop when full → count unchanged, no overflow.
- Pause E1 14 77 E1 F0 14 F0 77 → no events; next 1C → event 1C with ext=0, brk=0. Reset asserted mid-frame → all outputs 0, following frame decoded normally.
